conv_win_sched: RTL
===================

Name: conv_win_sched

Overview:
- Autonomous window scheduler for the 3x3 conv datapath. It replaces per-window host pokes of image load, trigger and pe clear.
- Walks every output position of an IMG_H x IMG_W image in raster order. Fetches pixel columns from a stripe memory and drives the circular image register's load and clear.
- Pulses the PE trigger once per window, waits for the datapath result, and emits the result tagged with its output row and column.
- Sits between the host register file and the conv PE array.

Parameters:
- IMG_H, 16, input image rows
- IMG_W, 15, input image columns
- K_H, 3, kernel rows (pixels per column word)
- K_W, 3, kernel columns (loads to fill a fresh window)
- ADDR_W, 8, stripe memory address width; must satisfy 2^ADDR_W >= (IMG_H-K_H+1)*IMG_W
- RES_W, 24, result width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a full-image pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse when the last result has been emitted
- mem_ren  out  1  stripe memory read enable
- mem_raddr  out  ADDR_W  word address = out_row*IMG_W + col
- mem_rdata  in  8*K_H  pixels (out_row..out_row+K_H-1, col), row k in byte k; valid 1 cycle after mem_ren
- img_clear  out  1  clear circular image register
- img_load_en  out  1  shift mem_rdata into the image register
- img_col  out  8*K_H  equals mem_rdata (combinational)
- pe_clear  out  1  clear PE accumulators
- pe_trigger  out  1  start one window calculation
- res_valid  in  1  datapath result ready; arbitrary delay >= 1 cycle after pe_trigger
- res_data  in  RES_W  datapath result
- out_valid  out  1  one-cycle result strobe
- out_data  out  RES_W  registered res_data
- out_row  out  $clog2(IMG_H)  output row tag
- out_col  out  $clog2(IMG_W)  output column tag

Behaviour:
- Output grid: OUT_H=IMG_H-K_H+1 rows, OUT_W=IMG_W-K_W+1 columns (14x13 at defaults).
- All outputs are registered except img_col.
- Reset value of every output is 0. Internal counters reset to 0 and state resets to IDLE.
- Reset mid-pass aborts immediately. No done pulse; a pending res_valid is ignored.
- States and transitions:
  - IDLE: start=1 -> ROW_CLR, busy<=1. start while busy is ignored.
  - ROW_CLR: one cycle with img_clear=1 and pe_clear=1. Sets fetch column col=0 and fill count fc=K_W -> FETCH.
  - FETCH: mem_ren=1, mem_raddr=out_row*IMG_W+col; col++, fc--. Stays while fc>1; when fc reaches 0 -> LOAD_TAIL.
  - Load timing: img_load_en is mem_ren delayed one cycle, so every fetch produces exactly one load, aligned with mem_rdata.
  - LOAD_TAIL: final load lands -> TRIG.
  - TRIG: pe_trigger=1 for exactly one cycle -> WAIT_RES.
  - WAIT_RES: hold until res_valid=1. Then out_valid=1 next cycle, with out_data=res_data and out_row/out_col = current window (out_col = col-K_W) -> ADVANCE.
  - ADVANCE:
    - out_col < OUT_W-1: pe_clear=1, fc=1 -> FETCH (single-column slide).
    - Else if out_row < OUT_H-1: out_row++ -> ROW_CLR.
    - Else -> DONE.
  - DONE: done=1 for one cycle, busy<=0 -> IDLE.
- res_valid outside WAIT_RES is ignored (no out_valid, no state change).
- res_valid in the same cycle as pe_trigger is ignored; minimum accepted latency is 1 cycle.
- Wrap-around: out_col resets to 0 only through ROW_CLR; the circular register is never slid across a row boundary.
- Cycle counts:
  - First window of a row: K_W fetch cycles before trigger.
  - Each later window: 1 fetch cycle.
  - Exactly OUT_H*OUT_W out_valid pulses per pass (182 at defaults).
- mem_raddr holds its last value when mem_ren=0.

Decomposition:
- Shared package conv_sched_pkg holds:
  - state enum sched_state_e {IDLE, ROW_CLR, FETCH, LOAD_TAIL, TRIG, WAIT_RES, ADVANCE, DONE}
  - localparams OUT_H, OUT_W
  - function win_addr(row,col) returning out_row*IMG_W+col
- One natural sub-module, win_pos_cnt: the out_row/out_col/col counter with last-column and last-row flags.
- The FSM stays in the top.

Test Plan:
- Defaults, memory word = address, res_valid 2 cycles after every trigger:
  - First reads at addresses 0,1,2, then trigger; next window reads only address 3.
  - 182 out_valid pulses, tags (0,0)..(13,12) in raster order, then one done pulse; busy falls with done.
- Row boundary: after tag (0,12), expect img_clear and pe_clear in the same cycle, then reads at 15,16,17; no read at address 15 while still on row 0.
- res_valid delayed 20 cycles on window (3,4): FSM holds in WAIT_RES with no mem_ren and no extra pe_trigger; exactly one out_valid, carrying that cycle's res_data, e.g. 24'h00ABCD.
- Spurious res_valid during FETCH, and start pulses mid-pass: no extra out_valid; pass completes with 182 results and one done.
- rst=1 for one cycle mid-pass at window (7,2): all outputs 0 next cycle, state IDLE, no done; a new start reruns from address 0 correctly.
- Parameter override IMG_H=5, IMG_W=4: 3x2=6 results, last tag (2,1), then done.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the conv window scheduler: FSM state encoding,
// default output-grid size and the stripe-memory address helper.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROW_CLR,
        FETCH,
        LOAD_TAIL,
        TRIG,
        WAIT_RES,
        ADVANCE,
        DONE
    } sched_state_e;

    localparam int IMG_H_DEF = 16;
    localparam int IMG_W_DEF = 15;
    localparam int K_H_DEF   = 3;
    localparam int K_W_DEF   = 3;

    localparam int OUT_H = IMG_H_DEF - K_H_DEF + 1;
    localparam int OUT_W = IMG_W_DEF - K_W_DEF + 1;

    // The stripe memory holds one K_H-pixel column word per (output row, image column).
    function automatic logic [31:0] win_addr(input logic [31:0] row,
                                             input logic [31:0] col,
                                             input logic [31:0] img_w);
        return row * img_w + col;
    endfunction

endpackage

// File: rtl/win_pos_cnt.sv
// Window position counter: output row, next fetch column and derived output column.
// Updates in the same cycle as the scheduler FSM; next-values are exported for address lookahead.
module win_pos_cnt #(
    parameter int IMG_H = 16,
    parameter int IMG_W = 15,
    parameter int K_H   = 3,
    parameter int K_W   = 3,
    parameter int RW    = $clog2(IMG_H),
    parameter int CW    = $clog2(IMG_W + 1),
    parameter int OCW   = $clog2(IMG_W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_pass_start,
    input  logic           i_row_clr,
    input  logic           i_col_inc,
    input  logic           i_row_inc,
    output logic [RW-1:0]  o_row,
    output logic [RW-1:0]  o_row_nxt,
    output logic [CW-1:0]  o_col_nxt,
    output logic [OCW-1:0] o_out_col,
    output logic           o_last_col,
    output logic           o_last_row
);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [RW-1:0] w_row_nxt;
    logic [CW-1:0] w_col_nxt;

    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (i_pass_start) begin
            w_row_nxt = '0;
        end else if (i_row_inc) begin
            w_row_nxt = r_row + 1'b1;
        end
        if (i_row_clr) begin
            w_col_nxt = '0;
        end else if (i_col_inc) begin
            w_col_nxt = r_col + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
        end
    end

    // r_col points at the next column to fetch, so the window's left edge trails it by K_W.
    assign o_out_col  = OCW'(r_col - CW'(K_W));
    assign o_last_col = (r_col == CW'(IMG_W));
    assign o_last_row = (r_row == RW'(IMG_H - K_H));
    assign o_row      = r_row;
    assign o_row_nxt  = w_row_nxt;
    assign o_col_nxt  = w_col_nxt;

endmodule

// File: rtl/conv_win_sched.sv
// Autonomous raster-order window scheduler: fetches column words, drives image-register load/clear,
// triggers the PE once per window and tags its result; stalls indefinitely in WAIT_RES for res_valid.
module conv_win_sched
    import conv_sched_pkg::*;
#(
    parameter int IMG_H  = 16,
    parameter int IMG_W  = 15,
    parameter int K_H    = 3,
    parameter int K_W    = 3,
    parameter int ADDR_W = 8,
    parameter int RES_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_ren,
    output logic [ADDR_W-1:0]        mem_raddr,
    input  logic [8*K_H-1:0]         mem_rdata,
    output logic                     img_clear,
    output logic                     img_load_en,
    output logic [8*K_H-1:0]         img_col,
    output logic                     pe_clear,
    output logic                     pe_trigger,
    input  logic                     res_valid,
    input  logic [RES_W-1:0]         res_data,
    output logic                     out_valid,
    output logic [RES_W-1:0]         out_data,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col
);

    localparam int RW  = $clog2(IMG_H);
    localparam int CW  = $clog2(IMG_W + 1);
    localparam int OCW = $clog2(IMG_W);
    localparam int FCW = $clog2(K_W + 1);

    sched_state_e r_state, w_state_nxt;
    logic [FCW-1:0] r_fc, w_fc_nxt;

    logic w_pass_start, w_row_clr, w_col_inc, w_row_inc, w_capture;
    logic [RW-1:0]  w_row, w_row_nxt;
    logic [CW-1:0]  w_col_nxt;
    logic [OCW-1:0] w_out_col;
    logic w_last_col, w_last_row;
    logic [ADDR_W-1:0] w_addr_nxt;

    logic              r_busy, r_done, r_mem_ren, r_img_clear, r_img_load_en;
    logic              r_pe_clear, r_pe_trigger, r_out_valid;
    logic [ADDR_W-1:0] r_mem_raddr;
    logic [RES_W-1:0]  r_out_data;
    logic [RW-1:0]     r_out_row;
    logic [OCW-1:0]    r_out_col;

    win_pos_cnt #(
        .IMG_H (IMG_H),
        .IMG_W (IMG_W),
        .K_H   (K_H),
        .K_W   (K_W),
        .RW    (RW),
        .CW    (CW),
        .OCW   (OCW)
    ) u_pos (
        .clk          (clk),
        .rst          (rst),
        .i_pass_start (w_pass_start),
        .i_row_clr    (w_row_clr),
        .i_col_inc    (w_col_inc),
        .i_row_inc    (w_row_inc),
        .o_row        (w_row),
        .o_row_nxt    (w_row_nxt),
        .o_col_nxt    (w_col_nxt),
        .o_out_col    (w_out_col),
        .o_last_col   (w_last_col),
        .o_last_row   (w_last_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_fc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fc    <= w_fc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fc_nxt     = r_fc;
        w_pass_start = 1'b0;
        w_row_clr    = 1'b0;
        w_col_inc    = 1'b0;
        w_row_inc    = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_pass_start = 1'b1;
                    w_state_nxt  = ROW_CLR;
                end
            end
            ROW_CLR: begin
                w_row_clr   = 1'b1;
                w_fc_nxt    = FCW'(K_W);
                w_state_nxt = FETCH;
            end
            FETCH: begin
                w_col_inc = 1'b1;
                w_fc_nxt  = r_fc - 1'b1;
                if (r_fc <= FCW'(1)) begin
                    w_state_nxt = LOAD_TAIL;
                end
            end
            LOAD_TAIL: w_state_nxt = TRIG;
            TRIG:      w_state_nxt = WAIT_RES;
            WAIT_RES: begin
                if (res_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ADVANCE;
                end
            end
            ADVANCE: begin
                // Slide by one column within a row; a new row always refills from column 0.
                if (!w_last_col) begin
                    w_fc_nxt    = FCW'(1);
                    w_state_nxt = FETCH;
                end else if (!w_last_row) begin
                    w_row_inc   = 1'b1;
                    w_state_nxt = ROW_CLR;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_addr_nxt = ADDR_W'(win_addr(32'(w_row_nxt), 32'(w_col_nxt), 32'(IMG_W)));

    // Outputs are registered from the next state so each strobe is aligned with its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_ren     <= 1'b0;
            r_mem_raddr   <= '0;
            r_img_clear   <= 1'b0;
            r_img_load_en <= 1'b0;
            r_pe_clear    <= 1'b0;
            r_pe_trigger  <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_row     <= '0;
            r_out_col     <= '0;
        end else begin
            r_busy        <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
            r_done        <= (w_state_nxt == DONE);
            r_mem_ren     <= (w_state_nxt == FETCH);
            if (w_state_nxt == FETCH) begin
                r_mem_raddr <= w_addr_nxt;
            end
            r_img_clear   <= (w_state_nxt == ROW_CLR);
            r_img_load_en <= r_mem_ren;
            r_pe_clear    <= (w_state_nxt == ROW_CLR) ||
                             ((w_state_nxt == ADVANCE) && !w_last_col);
            r_pe_trigger  <= (w_state_nxt == TRIG);
            r_out_valid   <= w_capture;
            if (w_capture) begin
                r_out_data <= res_data;
                r_out_row  <= w_row;
                r_out_col  <= w_out_col;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign mem_ren     = r_mem_ren;
    assign mem_raddr   = r_mem_raddr;
    assign img_clear   = r_img_clear;
    assign img_load_en = r_img_load_en;
    assign img_col     = mem_rdata;
    assign pe_clear    = r_pe_clear;
    assign pe_trigger  = r_pe_trigger;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_row     = r_out_row;
    assign out_col     = r_out_col;

endmodule
